os_block_assembler: RTL and testbench

- Sits directly upstream of the LTSSM ordered-set checker in the PCIe RX path.
- Takes the per-lane symbol stream from the descrambler/block aligner and collects the 16 symbols of each ordered-set block.
- Presents each completed block as one 128-bit word with a single-cycle valid strobe.
- Drops non-ordered-set blocks and truncated blocks, and counts truncations.

---
 rtl/os_block_assembler_if.sv | 26 ++
 rtl/os_block_assembler.sv | 94 +++++++++
 tb/tb_os_block_assembler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/os_block_assembler_if.sv
// Symbol-stream input and ordered-set output bundle of the ordered-set block assembler.
interface os_block_assembler_if #(
    parameter int unsigned SYMBOLS = 16,
    parameter int unsigned ERR_W   = 8
);
    logic [7:0]           sym_data;
    logic                 sym_valid;
    logic                 block_start;
    logic [1:0]           sync_header;
    logic [8*SYMBOLS-1:0] orderedset;
    logic                 valid;
    logic                 os_error;
    logic [ERR_W-1:0]     err_count;

    // Upstream aligner / downstream checker side.
    modport master (
        output sym_data, sym_valid, block_start, sync_header,
        input  orderedset, valid, os_error, err_count
    );

    // Assembler side.
    modport slave (
        input  sym_data, sym_valid, block_start, sync_header,
        output orderedset, valid, os_error, err_count
    );
endinterface

// File: rtl/os_block_assembler.sv
// Collects the SYMBOLS symbols of each ordered-set block into one wide word with a
// one-cycle valid strobe; drops non-OS blocks and counts truncated OS blocks.
module os_block_assembler #(
    parameter int unsigned SYMBOLS   = 16,
    parameter logic [1:0]  OS_HEADER = 2'b01,
    parameter int unsigned ERR_W     = 8
) (
    input logic                 clk,
    input logic                 reset,
    os_block_assembler_if.slave bus
);
    localparam int unsigned IdxW = $clog2(SYMBOLS);
    localparam int unsigned W    = 8 * SYMBOLS;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(SYMBOLS - 1);

    typedef enum logic [1:0] {StHunt, StCollect, StSkip} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     orderedset_q, orderedset_d;
    logic             valid_q, valid_d;
    logic             os_error_q, os_error_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    // Next-state: block framing, shadow fill, completion and truncation accounting.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        orderedset_d = orderedset_q;
        valid_d      = 1'b0;
        os_error_d   = 1'b0;
        err_count_d  = err_count_q;

        if (bus.sym_valid) begin
            if (bus.block_start) begin
                // A start while collecting truncates the block; the start symbol itself
                // is still evaluated below so nothing is lost.
                if (state_q == StCollect) begin
                    os_error_d = 1'b1;
                    if (err_count_q != {ERR_W{1'b1}}) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                end
                if (bus.sync_header == OS_HEADER) begin
                    shadow_d[7:0] = bus.sym_data;
                    idx_d         = IdxW'(1);
                    state_d       = StCollect;
                end else begin
                    idx_d   = '0;
                    state_d = StSkip;
                end
            end else if (state_q == StCollect) begin
                shadow_d[{idx_q, 3'b000} +: 8] = bus.sym_data;
                if (idx_q == LastIdx) begin
                    // Publish including the final symbol written this cycle.
                    orderedset_d = shadow_d;
                    valid_d      = 1'b1;
                    state_d      = StHunt;
                    idx_d        = '0;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StHunt;
            idx_q        <= '0;
            shadow_q     <= '0;
            orderedset_q <= '0;
            valid_q      <= 1'b0;
            os_error_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            orderedset_q <= orderedset_d;
            valid_q      <= valid_d;
            os_error_q   <= os_error_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.orderedset = orderedset_q;
    assign bus.valid      = valid_q;
    assign bus.os_error   = os_error_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_os_block_assembler.sv
// Directed self-checking bench for os_block_assembler.
module tb_os_block_assembler;
    logic clk;
    logic reset;

    os_block_assembler_if #(.SYMBOLS(16), .ERR_W(8)) bus ();

    os_block_assembler #(
        .SYMBOLS  (16),
        .OS_HEADER(2'b01),
        .ERR_W    (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Cycle counter and output monitor (sampled on the falling edge).
    int cyc = 0;
    int valid_cnt = 0;
    int err_pulse_cnt = 0;
    int consec_cnt = 0;
    int both_cnt = 0;
    int last_valid_cyc = -1;
    int prev_valid_cyc = -1;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid) begin
            valid_cnt      <= valid_cnt + 1;
            prev_valid_cyc <= last_valid_cyc;
            last_valid_cyc <= cyc;
            if (prev_valid) consec_cnt <= consec_cnt + 1;
        end
        if (bus.os_error) err_pulse_cnt <= err_pulse_cnt + 1;
        if (bus.valid && bus.os_error) both_cnt <= both_cnt + 1;
        prev_valid <= bus.valid;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] make_word(input logic [7:0] base, input logic [7:0] step);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(base + 8'(i) * step);
        return w;
    endfunction

    // Present one symbol for one clock; returns 1 time unit after the sampling edge.
    task automatic send(input logic start, input logic [1:0] hdr, input logic [7:0] data);
        bus.sym_valid   = 1'b1;
        bus.block_start = start;
        bus.sync_header = hdr;
        bus.sym_data    = data;
        @(posedge clk);
        #1;
        bus.sym_valid   = 1'b0;
        bus.block_start = 1'b0;
    endtask

    task automatic send_block(input logic [1:0] hdr, input logic [7:0] base,
                              input logic [7:0] step, input int n);
        send(1'b1, hdr, base);
        for (int i = 1; i < n; i++) send(1'b0, hdr, 8'(base + 8'(i) * step));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    int v0;
    int e0;
    int c0;

    initial begin
        reset           = 1'b1;
        bus.sym_data    = '0;
        bus.sym_valid   = 1'b0;
        bus.block_start = 1'b0;
        bus.sync_header = '0;
        #1;
        check("rst_orderedset", bus.orderedset, '0);
        check("rst_valid", {127'd0, bus.valid}, 128'd0);
        check("rst_os_error", {127'd0, bus.os_error}, 128'd0);
        check("rst_err_count", {120'd0, bus.err_count}, 128'd0);
        idle(2);
        reset = 1'b0;
        idle(1);

        // Basic block 0x00..0x0F.
        send_block(2'b01, 8'h00, 8'h01, 16);
        check("basic_valid", {127'd0, bus.valid}, 128'd1);
        check("basic_data", bus.orderedset, 128'h0F0E0D0C0B0A09080706050403020100);
        idle(1);
        check("basic_valid_drop", {127'd0, bus.valid}, 128'd0);
        check("basic_hold", bus.orderedset, 128'h0F0E0D0C0B0A09080706050403020100);

        // Same block with a 3-cycle gap after symbol 7.
        idle(2);
        c0 = cyc;
        send_block(2'b01, 8'h00, 8'h01, 8);
        idle(3);
        for (int i = 8; i < 16; i++) send(1'b0, 2'b01, 8'(i));
        check("gap_valid", {127'd0, bus.valid}, 128'd1);
        check("gap_data", bus.orderedset, 128'h0F0E0D0C0B0A09080706050403020100);
        idle(1);
        check("gap_latency", 128'(last_valid_cyc - c0), 128'd19);

        // Non-OS block is skipped, following OS block delivered.
        v0 = valid_cnt;
        e0 = err_pulse_cnt;
        send_block(2'b10, 8'h33, 8'h00, 16);
        send_block(2'b01, 8'hAA, 8'h00, 16);
        idle(2);
        check("skip_valid_count", 128'(valid_cnt - v0), 128'd1);
        check("skip_data", bus.orderedset, make_word(8'hAA, 8'h00));
        check("skip_no_error", 128'(err_pulse_cnt - e0), 128'd0);

        // Truncation after 9 symbols by a new OS block.
        do_reset();
        v0 = valid_cnt;
        send_block(2'b01, 8'h11, 8'h00, 9);
        check("trunc_no_err_yet", {127'd0, bus.os_error}, 128'd0);
        send(1'b1, 2'b01, 8'h55);
        check("trunc_os_error", {127'd0, bus.os_error}, 128'd1);
        check("trunc_err_count", {120'd0, bus.err_count}, 128'd1);
        for (int i = 1; i < 16; i++) send(1'b0, 2'b01, 8'h55);
        check("trunc_valid", {127'd0, bus.valid}, 128'd1);
        check("trunc_data", bus.orderedset, make_word(8'h55, 8'h00));
        idle(1);
        check("trunc_valid_count", 128'(valid_cnt - v0), 128'd1);

        // Back-to-back blocks with no bubble.
        send_block(2'b01, 8'h20, 8'h01, 16);
        check("b2b_a_valid", {127'd0, bus.valid}, 128'd1);
        check("b2b_a_data", bus.orderedset, make_word(8'h20, 8'h01));
        send_block(2'b01, 8'h40, 8'h03, 16);
        check("b2b_b_valid", {127'd0, bus.valid}, 128'd1);
        check("b2b_b_data", bus.orderedset, make_word(8'h40, 8'h03));
        idle(1);
        check("b2b_spacing", 128'(last_valid_cyc - prev_valid_cyc), 128'd16);

        // Reset mid-block discards the partial block.
        send_block(2'b01, 8'h77, 8'h01, 5);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_orderedset", bus.orderedset, '0);
        check("midrst_err_count", {120'd0, bus.err_count}, 128'd0);
        idle(1);
        reset = 1'b0;
        v0 = valid_cnt;
        for (int i = 0; i < 11; i++) send(1'b0, 2'b01, 8'(8'h80 + i));
        idle(2);
        check("midrst_no_valid", 128'(valid_cnt - v0), 128'd0);
        check("midrst_data", bus.orderedset, '0);
        check("midrst_valid", {127'd0, bus.valid}, 128'd0);

        // Error counter saturation: N+1 consecutive OS starts give N truncations.
        do_reset();
        for (int i = 0; i < 201; i++) send(1'b1, 2'b01, 8'(i));
        check("sat_count_200", {120'd0, bus.err_count}, 128'd200);
        for (int i = 0; i < 100; i++) send(1'b1, 2'b01, 8'(i));
        check("sat_count_255", {120'd0, bus.err_count}, 128'd255);
        idle(2);

        check("never_consec_valid", 128'(consec_cnt), 128'd0);
        check("never_valid_and_error", 128'(both_cnt), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
